// File: rtl/mux4_cmos.sv
// mux4_cmos: 4-to-1, 1-bit multiplexer built as a static complementary CMOS
// AND-OR-INVERT gate followed by an output inverter, using nmos/pmos switch
// primitives. A behavioural flop provides a clocked copy of the mux output.
// X/Z handling on selects and data comes only from the switch semantics:
// a non-selected data bit sits in a branch whose other series devices are
// off, so it cannot reach w4.
module mux4_cmos (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i,
    input  logic       s0,
    input  logic       s1,
    output wire        y,
    output logic       y_q
);

    supply1 vdd;
    supply0 gnd;

    // Complemented selects feed the term literals.
    wire ns0;
    wire ns1;
    assign ns0 = ~s0;
    assign ns1 = ~s1;

    // AOI output node: w4 = ~(T0 | T1 | T2 | T3).
    wire w4;

    // Pull-down series nodes, two per branch (branch k selects i[k]).
    wire w_pd0_a, w_pd0_b;
    wire w_pd1_a, w_pd1_b;
    wire w_pd2_a, w_pd2_b;
    wire w_pd3_a, w_pd3_b;

    // Pull-up nodes between the four series stages.
    wire w_pu_1, w_pu_2, w_pu_3;

    // Pull-down branch T0 = ~s1 & ~s0 & i[0]
    nmos n_t0_a (w4,      w_pd0_a, ns1);
    nmos n_t0_b (w_pd0_a, w_pd0_b, ns0);
    nmos n_t0_c (w_pd0_b, gnd,     i[0]);

    // Pull-down branch T1 = ~s1 & s0 & i[1]
    nmos n_t1_a (w4,      w_pd1_a, ns1);
    nmos n_t1_b (w_pd1_a, w_pd1_b, s0);
    nmos n_t1_c (w_pd1_b, gnd,     i[1]);

    // Pull-down branch T2 = s1 & ~s0 & i[2]
    nmos n_t2_a (w4,      w_pd2_a, s1);
    nmos n_t2_b (w_pd2_a, w_pd2_b, ns0);
    nmos n_t2_c (w_pd2_b, gnd,     i[2]);

    // Pull-down branch T3 = s1 & s0 & i[3]
    nmos n_t3_a (w4,      w_pd3_a, s1);
    nmos n_t3_b (w_pd3_a, w_pd3_b, s0);
    nmos n_t3_c (w_pd3_b, gnd,     i[3]);

    // Pull-up stage for T0: conducts when any T0 literal is low.
    pmos p_t0_a (w_pu_1, vdd, ns1);
    pmos p_t0_b (w_pu_1, vdd, ns0);
    pmos p_t0_c (w_pu_1, vdd, i[0]);

    // Pull-up stage for T1.
    pmos p_t1_a (w_pu_2, w_pu_1, ns1);
    pmos p_t1_b (w_pu_2, w_pu_1, s0);
    pmos p_t1_c (w_pu_2, w_pu_1, i[1]);

    // Pull-up stage for T2.
    pmos p_t2_a (w_pu_3, w_pu_2, s1);
    pmos p_t2_b (w_pu_3, w_pu_2, ns0);
    pmos p_t2_c (w_pu_3, w_pu_2, i[2]);

    // Pull-up stage for T3, closing the chain onto w4.
    pmos p_t3_a (w4, w_pu_3, s1);
    pmos p_t3_b (w4, w_pu_3, s0);
    pmos p_t3_c (w4, w_pu_3, i[3]);

    // Output inverter restores the true mux polarity.
    pmos p_inv (y, vdd, w4);
    nmos n_inv (y, gnd, w4);

    logic r_y_q;

    // Output register: clocked copy of y, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y_q <= 1'b0;
        end else begin
            r_y_q <= y;
        end
    end

    assign y_q = r_y_q;

endmodule

// File: tb/tb_mux4_cmos.sv
// Directed self-checking bench for mux4_cmos: select sweep, exhaustive
// function with w4 probe, unknown-input isolation, register latency and
// asynchronous reset behaviour.
module tb_mux4_cmos;

    logic       clk;
    logic       rst_n;
    logic [3:0] i;
    logic       s0;
    logic       s1;
    wire        y;
    logic       y_q;

    int n_checks;
    int n_fail;

    mux4_cmos dut (
        .clk   (clk),
        .rst_n (rst_n),
        .i     (i),
        .s0    (s0),
        .s1    (s1),
        .y     (y),
        .y_q   (y_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Four-state sum-of-products reference of the mux function.
    function automatic logic mux_ref(input logic [3:0] d, input logic a1, input logic a0);
        logic t0, t1, t2, t3;
        t0 = ~a1 & ~a0 & d[0];
        t1 = ~a1 &  a0 & d[1];
        t2 =  a1 & ~a0 & d[2];
        t3 =  a1 &  a0 & d[3];
        return t0 | t1 | t2 | t3;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        i     = 4'b0100;
        s1    = 1'b1;
        s0    = 1'b0;
        #1;
        n_checks++;
        if (y_q !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_yq: got %b want %b", y_q, 1'b0);
        end
        n_checks++;
        if (y !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_y_unaffected: got %b want %b", y, 1'b1);
        end
        @(posedge clk); #1;
        n_checks++;
        if (y_q !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_yq_hold_edge: got %b want %b", y_q, 1'b0);
        end
    endtask

    task automatic test_select_sweep();
        logic [3:0] vi [4];
        logic [1:0] vs [4];
        logic       ve [4];
        vi[0] = 4'b0000; vs[0] = 2'b00; ve[0] = 1'b0;
        vi[1] = 4'b0010; vs[1] = 2'b01; ve[1] = 1'b1;
        vi[2] = 4'b0000; vs[2] = 2'b10; ve[2] = 1'b0;
        vi[3] = 4'b1000; vs[3] = 2'b11; ve[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            i  = vi[k];
            s1 = vs[k][1];
            s0 = vs[k][0];
            #1;
            n_checks++;
            if (y !== ve[k]) begin
                n_fail++;
                $display("FAIL sweep_%0d: got %b want %b", k, y, ve[k]);
            end
            #9;
        end
    endtask

    task automatic test_exhaustive();
        logic [5:0] v;
        logic       e;
        for (int k = 0; k < 64; k++) begin
            v  = 6'(k);
            i  = v[3:0];
            s0 = v[4];
            s1 = v[5];
            e  = v[{30'd0, v[5:4]}];
            #1;
            n_checks++;
            if (y !== e) begin
                n_fail++;
                $display("FAIL exh_y i=%b s=%b%b: got %b want %b", i, s1, s0, y, e);
            end
            n_checks++;
            if (dut.w4 !== ~e) begin
                n_fail++;
                $display("FAIL exh_w4 i=%b s=%b%b: got %b want %b", i, s1, s0, dut.w4, ~e);
            end
        end
    endtask

    task automatic test_isolation();
        logic e;
        s1 = 1'b0;
        s0 = 1'b1;
        i  = 4'b1101;
        #1;
        n_checks++;
        if (y !== 1'b0) begin
            n_fail++;
            $display("FAIL iso_base: got %b want %b", y, 1'b0);
        end
        i = {1'bx, 1'bx, 1'b0, 1'bx};
        #1;
        n_checks++;
        if (y !== 1'b0) begin
            n_fail++;
            $display("FAIL iso_unsel_x: got %b want %b", y, 1'b0);
        end
        i  = 4'b1101;
        s0 = 1'bx;
        e  = mux_ref(i, s1, s0);
        #1;
        n_checks++;
        if (y !== e) begin
            n_fail++;
            $display("FAIL iso_sel_x: got %b want %b", y, e);
        end
        s0 = 1'b0;
        #1;
    endtask

    task automatic test_register_latency();
        logic prev_y;
        rst_n = 1'b1;
        i     = 4'b1010;
        s1    = 1'b0;
        s0    = 1'b0;
        @(negedge clk);
        prev_y = 1'b0;
        for (int k = 0; k < 6; k++) begin
            s0 = k[0];
            prev_y = mux_ref(i, s1, s0);
            @(posedge clk); #1;
            n_checks++;
            if (y_q !== prev_y) begin
                n_fail++;
                $display("FAIL latency_%0d: got %b want %b", k, y_q, prev_y);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        rst_n = 1'b1;
        i     = 4'b1111;
        s1    = 1'b1;
        s0    = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (y_q !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_pre: got %b want %b", y_q, 1'b1);
        end
        #2;
        rst_n = 1'b0;
        #0; #0;
        #1;
        n_checks++;
        if (y_q !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_immediate: got %b want %b", y_q, 1'b0);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (y_q !== 1'b0) begin
                n_fail++;
                $display("FAIL areset_hold_%0d: got %b want %b", k, y_q, 1'b0);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (y_q !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_release: got %b want %b", y_q, 1'b1);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_select_sweep();
        test_exhaustive();
        test_isolation();
        test_register_latency();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
